// File: rtl/iq_issue_select_pkg.sv
// iq_issue_select_pkg
// Shared definitions for the issue-select slice:
//   - default NUM_ENTRY / PAYLOAD_W / ROB index width constants
//   - rob_ptr_t : {robidx_flag, robidx} pair
//   - rob_older : age compare of two ROB pointers with wrap-flag handling
// The ROB index width comes from `ROB_SIZE_LOG when the build supplies it.
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 5
`endif

package iq_issue_select_pkg;

  localparam int NUM_ENTRY_DEF = 8;
  localparam int PAYLOAD_W_DEF = 160;
  localparam int ROB_LOG_DEF   = `ROB_SIZE_LOG;

  typedef struct packed {
    logic                   flag;
    logic [ROB_LOG_DEF-1:0] idx;
  } rob_ptr_t;

  // True when a is strictly older than b. Same wrap flag: smaller index is
  // older. Different flags: b has wrapped past a, so the larger index is older.
  function automatic logic rob_older(input rob_ptr_t a, input rob_ptr_t b);
    logic res;
    if (a.flag == b.flag) begin
      res = (a.idx < b.idx);
    end else begin
      res = (a.idx > b.idx);
    end
    return res;
  endfunction

endpackage

// File: rtl/iq_issue_select_if.sv
// iq_issue_select_if
// Valid/ready dequeue channel from the issue select stage to an execution unit.
//   deq_valid        master -> slave  uop valid
//   deq_ready        slave  -> master execution unit accepts
//   deq_robidx_flag  master -> slave  ROB wrap flag of the uop
//   deq_robidx       master -> slave  ROB index of the uop
//   deq_payload      master -> slave  opaque uop payload
interface iq_issue_select_if
  import iq_issue_select_pkg::*;
#(
  parameter int ROB_LOG   = ROB_LOG_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
);

  logic                 deq_valid;
  logic                 deq_ready;
  logic                 deq_robidx_flag;
  logic [ROB_LOG-1:0]   deq_robidx;
  logic [PAYLOAD_W-1:0] deq_payload;

  modport master (
    output deq_valid,
    output deq_robidx_flag,
    output deq_robidx,
    output deq_payload,
    input  deq_ready
  );

  modport slave (
    input  deq_valid,
    input  deq_robidx_flag,
    input  deq_robidx,
    input  deq_payload,
    output deq_ready
  );

endinterface

// File: rtl/iq_age_select.sv
// iq_age_select
// Purely combinational oldest-ready picker. A binary tournament tree of
// pairwise rob_older comparisons reduces the ready entries to one winner.
//   ready   in   NUM_ENTRY  per-entry ready_to_go
//   ptr     in   NUM_ENTRY  per-entry ROB pointer {flag, idx}
//   oldest  out  NUM_ENTRY  one-hot oldest ready entry, zero if none ready
// On identical pointers the left (lower-numbered) contender is kept, so the
// lower entry number wins ties.
module iq_age_select
  import iq_issue_select_pkg::*;
#(
  parameter int NUM_ENTRY = NUM_ENTRY_DEF
) (
  input  logic     [NUM_ENTRY-1:0] ready,
  input  rob_ptr_t [NUM_ENTRY-1:0] ptr,
  output logic     [NUM_ENTRY-1:0] oldest
);

  localparam int SEL_W  = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;
  localparam int LEAVES = 1 << SEL_W;

  // Heap-ordered tree: node 1 is the root, leaves live at LEAVES..2*LEAVES-1.
  logic             node_v   [2*LEAVES];
  rob_ptr_t         node_ptr [2*LEAVES];
  logic [SEL_W-1:0] node_sel [2*LEAVES];

  // Tournament tree: load leaves, then reduce pairs toward the root.
  always_comb begin : tree
    logic take_right;
    take_right = 1'b0;
    for (int k = 0; k < 2*LEAVES; k++) begin
      node_v[k]   = 1'b0;
      node_ptr[k] = '0;
      node_sel[k] = '0;
    end
    for (int i = 0; i < LEAVES; i++) begin
      node_sel[LEAVES+i] = SEL_W'(i);
      if (i < NUM_ENTRY) begin
        node_v[LEAVES+i]   = ready[i];
        node_ptr[LEAVES+i] = ptr[i];
      end else begin
        node_v[LEAVES+i]   = 1'b0;
        node_ptr[LEAVES+i] = '0;
      end
    end
    for (int k = LEAVES - 1; k >= 1; k--) begin
      take_right = node_v[2*k+1] &&
                   (!node_v[2*k] || rob_older(node_ptr[2*k+1], node_ptr[2*k]));
      if (take_right) begin
        node_v[k]   = 1'b1;
        node_ptr[k] = node_ptr[2*k+1];
        node_sel[k] = node_sel[2*k+1];
      end else begin
        node_v[k]   = node_v[2*k];
        node_ptr[k] = node_ptr[2*k];
        node_sel[k] = node_sel[2*k];
      end
    end
  end

  // Decode the root winner into a one-hot vector.
  always_comb begin
    oldest = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      oldest[i] = node_v[1] && (node_sel[1] == SEL_W'(i));
    end
  end

endmodule

// File: rtl/iq_issue_select.sv
// iq_issue_select
// Selects the oldest ready issue-queue entry each cycle, pulses a one-hot
// grant back to it and captures its uop into a single output register that
// feeds the execution unit over a valid/ready channel. A flush squashes the
// held uop when it is strictly younger than the flushing instruction.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   entry_ready               per-entry ready_to_go
//   entry_robidx_flag         per-entry ROB wrap flag
//   entry_robidx              per-entry ROB index, entry i at [i*ROB_LOG +: ROB_LOG]
//   entry_payload             per-entry payload, entry i at [i*PAYLOAD_W +: PAYLOAD_W]
//   issue_grant               one-hot (or zero) issue pulse, same cycle
//   deq                       dequeue channel (iq_issue_select_if.master)
//   flush_valid/_robidx_flag/_robidx   redirect and its ROB pointer
// Optional macro IQ_ISSUE_PERF_CNT_EN adds saturating 64-bit counters
//   perf_issue_cnt, perf_stall_cnt, perf_flush_kill_cnt.
module iq_issue_select
  import iq_issue_select_pkg::*;
#(
  parameter int NUM_ENTRY = NUM_ENTRY_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int ROB_LOG   = ROB_LOG_DEF
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_ENTRY-1:0]           entry_ready,
  input  logic [NUM_ENTRY-1:0]           entry_robidx_flag,
  input  logic [NUM_ENTRY*ROB_LOG-1:0]   entry_robidx,
  input  logic [NUM_ENTRY*PAYLOAD_W-1:0] entry_payload,
  output logic [NUM_ENTRY-1:0]           issue_grant,
  iq_issue_select_if.master              deq,
  input  logic                           flush_valid,
  input  logic                           flush_robidx_flag,
  input  logic [ROB_LOG-1:0]             flush_robidx
`ifdef IQ_ISSUE_PERF_CNT_EN
  ,
  output logic [63:0]                    perf_issue_cnt,
  output logic [63:0]                    perf_stall_cnt,
  output logic [63:0]                    perf_flush_kill_cnt
`endif
);

  rob_ptr_t [NUM_ENTRY-1:0] entry_ptr;
  logic     [NUM_ENTRY-1:0] oldest;
  rob_ptr_t                 flush_ptr;
  rob_ptr_t                 sel_ptr;
  logic [PAYLOAD_W-1:0]     sel_payload;

  logic                 held_valid;
  rob_ptr_t             held_ptr;
  logic [PAYLOAD_W-1:0] held_payload;

  logic slot_free;
  logic any_ready;
  logic grant_fire;
  logic kill;

  // Unpack the flat per-entry ROB index bus into pointer structs.
  always_comb begin
    entry_ptr = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      entry_ptr[i].flag = entry_robidx_flag[i];
      entry_ptr[i].idx  = entry_robidx[i*ROB_LOG +: ROB_LOG];
    end
  end

  iq_age_select #(
    .NUM_ENTRY (NUM_ENTRY)
  ) u_age_select (
    .ready  (entry_ready),
    .ptr    (entry_ptr),
    .oldest (oldest)
  );

  // Grant qualification. reset_n is folded in so an asserted reset kills the
  // grant immediately rather than at the next edge.
  always_comb begin
    flush_ptr.flag = flush_robidx_flag;
    flush_ptr.idx  = flush_robidx;
    slot_free  = !held_valid || deq.deq_ready;
    any_ready  = |entry_ready;
    grant_fire = reset_n && slot_free && !flush_valid && any_ready;
    issue_grant = grant_fire ? oldest : '0;
    // Held uop strictly younger than the flush point is squashed.
    kill = flush_valid && held_valid && rob_older(flush_ptr, held_ptr);
  end

  // One-hot AND-OR mux of the winning entry's pointer and payload.
  always_comb begin
    sel_ptr     = '0;
    sel_payload = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      sel_ptr     = sel_ptr | ({$bits(rob_ptr_t){oldest[i]}} & entry_ptr[i]);
      sel_payload = sel_payload |
                    ({PAYLOAD_W{oldest[i]}} & entry_payload[i*PAYLOAD_W +: PAYLOAD_W]);
    end
  end

  // Output valid: load on grant, drop on squash or on drain without refill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_valid <= 1'b0;
    end else if (grant_fire) begin
      held_valid <= 1'b1;
    end else if (kill || deq.deq_ready) begin
      held_valid <= 1'b0;
    end else begin
      held_valid <= held_valid;
    end
  end

  // Output data: captured only on grant, otherwise held stable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_ptr     <= '0;
      held_payload <= '0;
    end else if (grant_fire) begin
      held_ptr     <= sel_ptr;
      held_payload <= sel_payload;
    end else begin
      held_ptr     <= held_ptr;
      held_payload <= held_payload;
    end
  end

  assign deq.deq_valid       = held_valid;
  assign deq.deq_robidx_flag = held_ptr.flag;
  assign deq.deq_robidx      = held_ptr.idx;
  assign deq.deq_payload     = held_payload;

`ifdef IQ_ISSUE_PERF_CNT_EN
  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    logic [63:0] r;
    if (v == {64{1'b1}}) begin
      r = v;
    end else begin
      r = v + 64'd1;
    end
    return r;
  endfunction

  // Saturating event counters: grants, slot-busy stalls, flush squashes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt      <= 64'd0;
      perf_stall_cnt      <= 64'd0;
      perf_flush_kill_cnt <= 64'd0;
    end else begin
      perf_issue_cnt      <= grant_fire ? sat_inc(perf_issue_cnt) : perf_issue_cnt;
      perf_stall_cnt      <= (any_ready && !slot_free) ? sat_inc(perf_stall_cnt)
                                                       : perf_stall_cnt;
      perf_flush_kill_cnt <= kill ? sat_inc(perf_flush_kill_cnt) : perf_flush_kill_cnt;
    end
  end
`endif

endmodule
